// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch, load and store.
// Accesses are serialised through a four-state FSM. Read data is returned with
// one-cycle valid pulses. Loads and stores stall the pipeline until they complete.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // Instruction fetch
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  // Load
  input  logic              ld_req_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  output logic              ld_gnt_o,
  output logic              ld_rvalid_o,
  output logic [DATA_W-1:0] ld_rdata_o,
  // Store
  input  logic              st_req_i,
  input  logic [ADDR_W-1:0] st_addr_i,
  input  logic [DATA_W-1:0] st_wdata_i,
  output logic              st_gnt_o,
  output logic              st_done_o,
  // Memory macro
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  // Pipeline
  output logic              stall_o
);

  localparam int unsigned LatW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY + 1) : 1;
  localparam int unsigned StvW = $clog2(STARVE_LIMIT + 1);

  localparam logic [StvW-1:0] StarveMax = StvW'(STARVE_LIMIT);
  localparam logic [LatW-1:0] LatInit   = LatW'(MEM_LATENCY);
  // Counter value in the last WAIT cycle, i.e. it reaches 1 at the coming edge.
  localparam logic [LatW-1:0] LatLast   = LatW'(2);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;
  typedef enum logic [1:0] {SrcNone, SrcIf, SrcLd, SrcSt} src_e;

  state_e            state_q, state_d;
  src_e              src_q, src_d;
  src_e              win;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [StvW-1:0]   starve_q, starve_d;
  logic [LatW-1:0]   lat_q, lat_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;
  logic              capture;

  // Arbitration: store > load > fetch, unless fetch has been starved too long.
  always_comb begin
    win = SrcNone;
    if (state_q == StIdle) begin
      if (if_req_i && (starve_q == StarveMax)) begin
        win = SrcIf;
      end else if (st_req_i) begin
        win = SrcSt;
      end else if (ld_req_i) begin
        win = SrcLd;
      end else if (if_req_i) begin
        win = SrcIf;
      end
    end
  end

  // Next-state logic for the access FSM, request registers and read-data holders.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    starve_d   = starve_q;
    lat_d      = lat_q;
    if_rdata_d = if_rdata_q;
    ld_rdata_d = ld_rdata_q;
    capture    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (win != SrcNone) begin
          state_d = StIssue;
          src_d   = win;
          case (win)
            SrcIf: begin
              addr_d   = if_addr_i;
              starve_d = '0;
            end
            SrcLd: addr_d = ld_addr_i;
            SrcSt: begin
              addr_d  = st_addr_i;
              wdata_d = st_wdata_i;
            end
            default: ;
          endcase
          // Data-side grant while fetch is waiting: count towards starvation.
          if ((win != SrcIf) && if_req_i && (starve_q != StarveMax)) begin
            starve_d = starve_q + StvW'(1);
          end
        end
      end
      StIssue: begin
        if (src_q == SrcSt) begin
          state_d = StResp;
        end else if (MEM_LATENCY == 1) begin
          // Single-cycle memory: data is already valid at the end of ISSUE.
          capture = 1'b1;
          state_d = StResp;
        end else begin
          lat_d   = LatInit;
          state_d = StWait;
        end
      end
      StWait: begin
        lat_d = lat_q - LatW'(1);
        if (lat_q == LatLast) begin
          capture = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (capture) begin
      if (src_q == SrcIf) begin
        if_rdata_d = mem_rdata_i;
      end else begin
        ld_rdata_d = mem_rdata_i;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      src_q      <= SrcNone;
      addr_q     <= '0;
      wdata_q    <= '0;
      starve_q   <= '0;
      lat_q      <= '0;
      if_rdata_q <= '0;
      ld_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      starve_q   <= starve_d;
      lat_q      <= lat_d;
      if_rdata_q <= if_rdata_d;
      ld_rdata_q <= ld_rdata_d;
    end
  end

  // Memory strobes are driven only in ISSUE; everything else idles at 0.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (state_q == StIssue) begin
      mem_en_o   = 1'b1;
      mem_addr_o = addr_q;
      if (src_q == SrcSt) begin
        mem_we_o    = 1'b1;
        mem_wdata_o = wdata_q;
      end
    end
  end

  // Grants and stall are combinational; gate them so reset forces them low.
  assign if_gnt_o    = rst_n && (win == SrcIf);
  assign ld_gnt_o    = rst_n && (win == SrcLd);
  assign st_gnt_o    = rst_n && (win == SrcSt);

  assign if_rvalid_o = (state_q == StResp) && (src_q == SrcIf);
  assign ld_rvalid_o = (state_q == StResp) && (src_q == SrcLd);
  assign st_done_o   = (state_q == StResp) && (src_q == SrcSt);

  assign if_rdata_o  = if_rdata_q;
  assign ld_rdata_o  = ld_rdata_q;

  assign stall_o = rst_n && (ld_req_i || st_req_i) && !(ld_rvalid_o || st_done_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a single-cycle instance (STARVE_LIMIT=2) and a
// three-cycle-latency instance, a table of directed cycles, hand sequences for
// multi-cycle corners and a randomized run against a timestamp reference model.
module tb_mem_port_arbiter;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 16;
  localparam int unsigned LAT_A = 1;
  localparam int unsigned STV_A = 2;
  localparam int unsigned LAT_B = 3;
  localparam int unsigned STV_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // DUT A signals
  logic          rst_n_a, if_req_a, ld_req_a, st_req_a;
  logic [AW-1:0] if_addr_a, ld_addr_a, st_addr_a, mem_addr_a;
  logic [DW-1:0] st_wdata_a, mem_rdata_a, mem_wdata_a, if_rdata_a, ld_rdata_a;
  logic          if_gnt_a, if_rvalid_a, ld_gnt_a, ld_rvalid_a, st_gnt_a, st_done_a;
  logic          mem_en_a, mem_we_a, stall_a;
  // DUT B signals
  logic          rst_n_b, if_req_b, ld_req_b, st_req_b;
  logic [AW-1:0] if_addr_b, ld_addr_b, st_addr_b, mem_addr_b;
  logic [DW-1:0] st_wdata_b, mem_rdata_b, mem_wdata_b, if_rdata_b, ld_rdata_b;
  logic          if_gnt_b, if_rvalid_b, ld_gnt_b, ld_rvalid_b, st_gnt_b, st_done_b;
  logic          mem_en_b, mem_we_b, stall_b;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT_A), .STARVE_LIMIT(STV_A)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n_a),
    .if_req_i(if_req_a), .if_addr_i(if_addr_a), .if_gnt_o(if_gnt_a),
    .if_rvalid_o(if_rvalid_a), .if_rdata_o(if_rdata_a),
    .ld_req_i(ld_req_a), .ld_addr_i(ld_addr_a), .ld_gnt_o(ld_gnt_a),
    .ld_rvalid_o(ld_rvalid_a), .ld_rdata_o(ld_rdata_a),
    .st_req_i(st_req_a), .st_addr_i(st_addr_a), .st_wdata_i(st_wdata_a),
    .st_gnt_o(st_gnt_a), .st_done_o(st_done_a),
    .mem_en_o(mem_en_a), .mem_we_o(mem_we_a), .mem_addr_o(mem_addr_a),
    .mem_wdata_o(mem_wdata_a), .mem_rdata_i(mem_rdata_a), .stall_o(stall_a)
  );

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT_B), .STARVE_LIMIT(STV_B)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n_b),
    .if_req_i(if_req_b), .if_addr_i(if_addr_b), .if_gnt_o(if_gnt_b),
    .if_rvalid_o(if_rvalid_b), .if_rdata_o(if_rdata_b),
    .ld_req_i(ld_req_b), .ld_addr_i(ld_addr_b), .ld_gnt_o(ld_gnt_b),
    .ld_rvalid_o(ld_rvalid_b), .ld_rdata_o(ld_rdata_b),
    .st_req_i(st_req_b), .st_addr_i(st_addr_b), .st_wdata_i(st_wdata_b),
    .st_gnt_o(st_gnt_b), .st_done_o(st_done_b),
    .mem_en_o(mem_en_b), .mem_we_o(mem_we_b), .mem_addr_o(mem_addr_b),
    .mem_wdata_o(mem_wdata_b), .mem_rdata_i(mem_rdata_b), .stall_o(stall_b)
  );

  // Memory contents: a fixed function of the address with two pinned locations.
  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    logic [31:0] p;
    if (a == 16'h0010) return 16'hBEEF;
    if (a == 16'h0040) return 16'h00AA;
    p = {16'h0000, a} * 32'h0000_9E37;
    return p[15:0] ^ 16'h5A5A;
  endfunction

  // Garbage on the read bus whenever the memory is not presenting valid data.
  logic [DW-1:0] junk = '0;
  always @(posedge clk) junk <= DW'($urandom);

  // Memory A: latency 1, data valid in the strobe cycle.
  always_comb mem_rdata_a = mem_en_a ? mem_val(mem_addr_a) : junk;

  // Memory B: latency LAT_B, data valid only LAT_B-1 cycles after the strobe.
  int unsigned   rd_cnt_b  = 0;
  logic [AW-1:0] rd_addr_b = '0;
  always @(posedge clk) begin
    if (mem_en_b && !mem_we_b) begin
      rd_cnt_b  <= LAT_B - 1;
      rd_addr_b <= mem_addr_b;
    end else if (rd_cnt_b != 0) begin
      rd_cnt_b <= rd_cnt_b - 1;
    end
  end
  always_comb mem_rdata_b = (rd_cnt_b == 1) ? mem_val(rd_addr_b) : junk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Directed per-cycle vectors for DUT A.
  typedef struct {
    logic          if_req, ld_req, st_req;
    logic [AW-1:0] if_addr, ld_addr, st_addr;
    logic [DW-1:0] st_wdata;
    logic [2:0]    gnt;   // {if, ld, st}
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    resp;  // {if_rvalid, ld_rvalid, st_done}
    logic          stall;
    logic [DW-1:0] if_rdata, ld_rdata;
  } vec_t;

  function automatic vec_t mk(
    input logic i, input logic l, input logic s,
    input logic [AW-1:0] ia, input logic [AW-1:0] la, input logic [AW-1:0] sa,
    input logic [DW-1:0] wd, input logic [2:0] g, input logic en, input logic we,
    input logic [AW-1:0] ma, input logic [DW-1:0] mw, input logic [2:0] r,
    input logic st, input logic [DW-1:0] ird, input logic [DW-1:0] lrd);
    vec_t v;
    v.if_req = i;  v.ld_req = l;  v.st_req = s;
    v.if_addr = ia; v.ld_addr = la; v.st_addr = sa; v.st_wdata = wd;
    v.gnt = g; v.mem_en = en; v.mem_we = we; v.mem_addr = ma; v.mem_wdata = mw;
    v.resp = r; v.stall = st; v.if_rdata = ird; v.ld_rdata = lrd;
    return v;
  endfunction

  // Reference model state (timestamps of the single in-flight access).
  int            m_cyc, m_free, m_en_cyc, m_resp_cyc, m_kind, m_starve;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_if_rd, m_ld_rd;
  logic [2:0]    m_gnt;

  task automatic model_reset();
    m_cyc = 0; m_free = 0; m_en_cyc = -1; m_resp_cyc = -1; m_kind = 0; m_starve = 0;
    m_addr = '0; m_wdata = '0; m_if_rd = '0; m_ld_rd = '0; m_gnt = '0;
  endtask

  // Called once per cycle at the sampling point for DUT A.
  task automatic model_check();
    logic [2:0]    g, r;
    logic          en, we, st;
    logic [AW-1:0] ma;
    logic [DW-1:0] mw;
    g = '0;
    if (m_cyc >= m_free) begin
      if (if_req_a && m_starve == int'(STV_A)) g = 3'b100;
      else if (st_req_a) g = 3'b001;
      else if (ld_req_a) g = 3'b010;
      else if (if_req_a) g = 3'b100;
    end
    en = (m_cyc == m_en_cyc);
    we = en && (m_kind == 2);
    ma = en ? m_addr : '0;
    mw = we ? m_wdata : '0;
    r  = '0;
    if (m_cyc == m_resp_cyc) begin
      case (m_kind)
        0: begin r = 3'b100; m_if_rd = mem_val(m_addr); end
        1: begin r = 3'b010; m_ld_rd = mem_val(m_addr); end
        default: r = 3'b001;
      endcase
    end
    st = (ld_req_a || st_req_a) && !(r[1] || r[0]);
    chk("rnd_gnt", {if_gnt_a, ld_gnt_a, st_gnt_a}, g);
    chk("rnd_mem", {mem_en_a, mem_we_a, mem_addr_a, mem_wdata_a}, {en, we, ma, mw});
    chk("rnd_resp", {if_rvalid_a, ld_rvalid_a, st_done_a}, r);
    chk("rnd_stall", stall_a, st);
    chk("rnd_if_rdata", if_rdata_a, m_if_rd);
    chk("rnd_ld_rdata", ld_rdata_a, m_ld_rd);
    if (g != 0) begin
      m_kind     = g[2] ? 0 : (g[1] ? 1 : 2);
      m_addr     = g[2] ? if_addr_a : (g[1] ? ld_addr_a : st_addr_a);
      m_wdata    = st_wdata_a;
      m_en_cyc   = m_cyc + 1;
      m_resp_cyc = m_cyc + ((m_kind == 2) ? 2 : int'(LAT_A) + 1);
      m_free     = m_resp_cyc + 1;
      if (g[2]) m_starve = 0;
      else if (if_req_a && m_starve < int'(STV_A)) m_starve++;
    end
    m_gnt = g;
    m_cyc++;
  endtask

  // Random requesters: hold a request until granted, then re-roll.
  task automatic drive_random();
    if (!(if_req_a && !m_gnt[2])) begin
      if_req_a  = ($urandom_range(0, 2) != 0);
      if_addr_a = AW'($urandom);
    end
    if (!(ld_req_a && !m_gnt[1])) begin
      ld_req_a  = ($urandom_range(0, 1) != 0);
      ld_addr_a = AW'($urandom);
    end
    if (!(st_req_a && !m_gnt[0])) begin
      st_req_a   = ($urandom_range(0, 2) == 0);
      st_addr_a  = AW'($urandom);
      st_wdata_a = DW'($urandom);
    end
  endtask

  vec_t       tbl[14];
  logic [1:0] ord[6];
  int         got;

  initial begin
    logic [DW-1:0] x30, x50;
    x30 = mem_val(16'h0030);
    x50 = mem_val(16'h0050);
    //            i  l  s  if_addr  ld_addr  st_addr  wdata    gnt   en we addr mwd   resp st
    tbl[0]  = mk(0, 0, 0, 16'h0,    16'h0,   16'h0,   16'h0,    3'b000, 0, 0, 16'h0, 16'h0,
                 3'b000, 0, 16'h0, 16'h0);
    tbl[1]  = mk(1, 0, 0, 16'h0010, 16'h0,   16'h0,   16'h0,    3'b100, 0, 0, 16'h0, 16'h0,
                 3'b000, 0, 16'h0, 16'h0);
    tbl[2]  = mk(0, 0, 0, 16'h0010, 16'h0,   16'h0,   16'h0,    3'b000, 1, 0, 16'h0010, 16'h0,
                 3'b000, 0, 16'h0, 16'h0);
    tbl[3]  = mk(0, 0, 0, 16'h0010, 16'h0,   16'h0,   16'h0,    3'b000, 0, 0, 16'h0, 16'h0,
                 3'b100, 0, 16'hBEEF, 16'h0);
    tbl[4]  = mk(1, 1, 1, 16'h0050, 16'h0030, 16'h0020, 16'h1234, 3'b001, 0, 0, 16'h0, 16'h0,
                 3'b000, 1, 16'hBEEF, 16'h0);
    tbl[5]  = mk(1, 1, 0, 16'h0050, 16'h0030, 16'h0020, 16'h1234, 3'b000, 1, 1, 16'h0020,
                 16'h1234, 3'b000, 1, 16'hBEEF, 16'h0);
    tbl[6]  = mk(1, 1, 0, 16'h0050, 16'h0030, 16'h0020, 16'h1234, 3'b000, 0, 0, 16'h0, 16'h0,
                 3'b001, 0, 16'hBEEF, 16'h0);
    tbl[7]  = mk(1, 1, 0, 16'h0050, 16'h0030, 16'h0020, 16'h1234, 3'b010, 0, 0, 16'h0, 16'h0,
                 3'b000, 1, 16'hBEEF, 16'h0);
    tbl[8]  = mk(1, 1, 0, 16'h0050, 16'h0030, 16'h0020, 16'h1234, 3'b000, 1, 0, 16'h0030,
                 16'h0, 3'b000, 1, 16'hBEEF, 16'h0);
    tbl[9]  = mk(1, 1, 0, 16'h0050, 16'h0030, 16'h0020, 16'h1234, 3'b000, 0, 0, 16'h0, 16'h0,
                 3'b010, 0, 16'hBEEF, x30);
    tbl[10] = mk(1, 0, 0, 16'h0050, 16'h0030, 16'h0020, 16'h1234, 3'b100, 0, 0, 16'h0, 16'h0,
                 3'b000, 0, 16'hBEEF, x30);
    tbl[11] = mk(0, 0, 0, 16'h0050, 16'h0030, 16'h0020, 16'h1234, 3'b000, 1, 0, 16'h0050,
                 16'h0, 3'b000, 0, 16'hBEEF, x30);
    tbl[12] = mk(0, 0, 0, 16'h0050, 16'h0030, 16'h0020, 16'h1234, 3'b000, 0, 0, 16'h0, 16'h0,
                 3'b100, 0, x50, x30);
    tbl[13] = mk(0, 0, 0, 16'h0050, 16'h0030, 16'h0020, 16'h1234, 3'b000, 0, 0, 16'h0, 16'h0,
                 3'b000, 0, x50, x30);
    ord = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};

    rst_n_a = 1'b0; if_req_a = 1'b0; ld_req_a = 1'b0; st_req_a = 1'b0;
    if_addr_a = '0; ld_addr_a = '0; st_addr_a = '0; st_wdata_a = '0;
    rst_n_b = 1'b0; if_req_b = 1'b0; ld_req_b = 1'b0; st_req_b = 1'b0;
    if_addr_b = '0; ld_addr_b = '0; st_addr_b = '0; st_wdata_b = '0;
    tick();
    tick();
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;

    // ---- Table: reset state, single fetch, simultaneous requests (DUT A) ----
    foreach (tbl[i]) begin
      if_req_a = tbl[i].if_req;   ld_req_a = tbl[i].ld_req;   st_req_a = tbl[i].st_req;
      if_addr_a = tbl[i].if_addr; ld_addr_a = tbl[i].ld_addr; st_addr_a = tbl[i].st_addr;
      st_wdata_a = tbl[i].st_wdata;
      smp();
      chk($sformatf("tbl%0d_gnt", i), {if_gnt_a, ld_gnt_a, st_gnt_a}, tbl[i].gnt);
      chk($sformatf("tbl%0d_mem", i), {mem_en_a, mem_we_a, mem_addr_a, mem_wdata_a},
          {tbl[i].mem_en, tbl[i].mem_we, tbl[i].mem_addr, tbl[i].mem_wdata});
      chk($sformatf("tbl%0d_resp", i), {if_rvalid_a, ld_rvalid_a, st_done_a}, tbl[i].resp);
      chk($sformatf("tbl%0d_stall", i), stall_a, tbl[i].stall);
      chk($sformatf("tbl%0d_rdata", i), {if_rdata_a, ld_rdata_a},
          {tbl[i].if_rdata, tbl[i].ld_rdata});
      tick();
    end

    // ---- Starvation with STARVE_LIMIT=2 (DUT A) ----
    if_req_a = 1'b1; if_addr_a = 16'h0100;
    ld_req_a = 1'b1; ld_addr_a = 16'h0200;
    got = 0;
    for (int c = 0; c < 60 && got < 6; c++) begin
      smp();
      if (if_gnt_a || ld_gnt_a) begin
        chk($sformatf("starve_order%0d", got), {if_gnt_a, ld_gnt_a}, ord[got]);
        got++;
      end
      tick();
    end
    chk("starve_grant_count", got, 6);
    if_req_a = 1'b0; ld_req_a = 1'b0;
    repeat (4) tick();

    // ---- MEM_LATENCY=3 load (DUT B) ----
    ld_req_b = 1'b1; ld_addr_b = 16'h0040;
    for (int c = 0; c <= 5; c++) begin
      smp();
      chk($sformatf("lat_c%0d_gnt", c), ld_gnt_b, c == 0);
      chk($sformatf("lat_c%0d_mem_en", c), mem_en_b, c == 1);
      chk($sformatf("lat_c%0d_rvalid", c), ld_rvalid_b, c == 4);
      if (c == 1) chk("lat_mem_addr", mem_addr_b, 16'h0040);
      if (c == 4) chk("lat_rdata", ld_rdata_b, 16'h00AA);
      tick();
      if (c == 4) ld_req_b = 1'b0;
    end

    // ---- Reset during WAIT of a fetch (DUT B) ----
    if_req_b = 1'b1; if_addr_b = 16'h0060;
    smp(); chk("mid_rst_gnt", if_gnt_b, 1'b1); tick();
    if_req_b = 1'b0;
    smp(); chk("mid_rst_issue", mem_en_b, 1'b1); tick();
    if_req_b = 1'b1; ld_req_b = 1'b1; st_req_b = 1'b1;
    rst_n_b = 1'b0;
    #1;
    chk("mid_rst_ctl", {if_gnt_b, if_rvalid_b, ld_gnt_b, ld_rvalid_b, st_gnt_b, st_done_b,
                        mem_en_b, mem_we_b, stall_b}, 9'h0);
    chk("mid_rst_data", {if_rdata_b, ld_rdata_b, mem_addr_b, mem_wdata_b}, 64'h0);
    tick();
    ld_req_b = 1'b0; st_req_b = 1'b0; if_addr_b = 16'h0070;
    rst_n_b = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      smp();
      chk($sformatf("post_rst_c%0d_gnt", c), if_gnt_b, c == 0);
      chk($sformatf("post_rst_c%0d_rvalid", c), if_rvalid_b, c == 4);
      if (c == 4) chk("post_rst_rdata", if_rdata_b, mem_val(16'h0070));
      tick();
      if_req_b = 1'b0;
    end

    // ---- Load raised while a fetch is outstanding (DUT B) ----
    if_req_b = 1'b1; if_addr_b = 16'h0090;
    smp(); chk("late_if_gnt", if_gnt_b, 1'b1); tick();
    if_req_b = 1'b0; ld_req_b = 1'b1; ld_addr_b = 16'h0080;
    for (int c = 1; c <= 9; c++) begin
      smp();
      chk($sformatf("late_c%0d_ld_gnt", c), ld_gnt_b, c == 5);
      chk($sformatf("late_c%0d_stall", c), stall_b, c != 9);
      chk($sformatf("late_c%0d_ld_rvalid", c), ld_rvalid_b, c == 9);
      if (c == 9) chk("late_ld_rdata", ld_rdata_b, mem_val(16'h0080));
      tick();
    end
    ld_req_b = 1'b0;

    // ---- Randomized traffic against the reference model (DUT A) ----
    if_req_a = 1'b1; st_req_a = 1'b1; ld_req_a = 1'b1;
    rst_n_a = 1'b0;
    #1;
    chk("reset_ctl_a", {if_gnt_a, if_rvalid_a, ld_gnt_a, ld_rvalid_a, st_gnt_a, st_done_a,
                        mem_en_a, mem_we_a, stall_a}, 9'h0);
    chk("reset_data_a", {if_rdata_a, ld_rdata_a, mem_addr_a, mem_wdata_a}, 64'h0);
    tick();
    if_req_a = 1'b0; st_req_a = 1'b0; ld_req_a = 1'b0;
    rst_n_a = 1'b1;
    model_reset();
    for (int c = 0; c < 400; c++) begin
      drive_random();
      smp();
      model_check();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the single-ported data/instruction memory between three requesters: instruction fetch, execute-stage load and execute-stage store.
- Serialises accesses through a small FSM and returns read data with valid pulses.
- Raises `stall` to freeze the pipeline while a load/store is outstanding.
- Sits between the fetch/execute stages and the memory macro.

## Interface

Parameters:
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `MEM_LATENCY`, 1, cycles from `mem_en` to valid `mem_rdata` (≥1)
- `STARVE_LIMIT`, 4, consecutive data grants tolerated while fetch waits (≥1)

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `if_req` in 1: fetch read request
- `if_addr` in ADDR_W: fetch address
- `if_gnt` out 1: fetch request accepted
- `if_rvalid` out 1: fetch data valid
- `if_rdata` out DATA_W: fetch data
- `ld_req` in 1: load request
- `ld_addr` in ADDR_W: load address
- `ld_gnt` out 1: load request accepted
- `ld_rvalid` out 1: load data valid
- `ld_rdata` out DATA_W: load data
- `st_req` in 1: store request
- `st_addr` in ADDR_W: store address
- `st_wdata` in DATA_W: store data
- `st_gnt` out 1: store request accepted
- `st_done` out 1: store written
- `mem_en` out 1: memory access strobe
- `mem_we` out 1: write enable
- `mem_addr` out ADDR_W: memory address
- `mem_wdata` out DATA_W: memory write data
- `mem_rdata` in DATA_W: memory read data
- `stall` out 1: pipeline freeze

## Operation

**Reset.** `rst_n` low forces all of the following asynchronously:
- FSM to IDLE; starvation counter and latency counter to 0.
- Every output to 0, including `if_rdata`, `ld_rdata` and `stall`.
- Reset mid-access discards the in-flight response: no `rvalid`/`done` pulse after release.

**FSM states:**
- IDLE: arbitrate.
- ISSUE: drive memory for one cycle.
- WAIT: count latency; reads only.
- RESP: pulse valid/done.

**Arbitration (IDLE only).**
- Priority is store > load > fetch.
- Exception: if the starvation counter equals `STARVE_LIMIT` and `if_req`=1, fetch wins.
- The winner's `*_gnt` is a combinational one-cycle pulse.
- The winner's address and data are registered at the same edge. FSM moves IDLE→ISSUE.
- Requests seen outside IDLE get no grant.
- Requesters hold `req`, addr and wdata stable until `gnt`. They may drop `req` the cycle after `gnt`.

**Starvation counter.**
- Increments, saturating at `STARVE_LIMIT`, on each load/store grant while `if_req`=1.
- Cleared on a fetch grant.
- Unchanged otherwise.

**ISSUE.**
- `mem_en`=1 with `mem_addr` from the registered address.
- For a store: `mem_we`=1 and `mem_wdata`=`st_wdata`, then go to RESP.
- For a read: `mem_we`=0, load latency counter with `MEM_LATENCY`, then go to WAIT.
- `mem_en`, `mem_we`, `mem_addr` and `mem_wdata` are 0 in every state except ISSUE.

**WAIT.**
- Decrement the counter each cycle.
- When the counter reaches 1, capture `mem_rdata` into the winner's `*_rdata` register and go to RESP.

**RESP.**
- Pulse `if_rvalid`, `ld_rvalid` or `st_done` for one cycle.
- `*_rdata` holds its value until the next read for that requester.
- FSM returns to IDLE at the next edge.

**`stall`** is combinational: (`ld_req` | `st_req`) & ~(`ld_rvalid` | `st_done`).

## Timing

- Cycle 0 is the IDLE cycle in which the grant is given.
- Reads:
  - `mem_en` in cycle 1.
  - `mem_rdata` sampled at the end of cycle `MEM_LATENCY`.
  - `*_rvalid` in cycle `MEM_LATENCY`+1.
  - Next grant possible in cycle `MEM_LATENCY`+2.
- Stores: `mem_en`/`mem_we` in cycle 1, `st_done` in cycle 2, next grant in cycle 3.
- At most one grant per cycle and one access in flight.
- No combinational path from `mem_rdata` to any output.

## Test plan

- **Reset and single fetch:** reset, then `if_req`=1 with `if_addr`=0x0010, memory returns 0xBEEF, `MEM_LATENCY`=1.
  - `if_gnt` in cycle 0, `mem_en`/`mem_addr`=0x0010 in cycle 1, `if_rvalid`/`if_rdata`=0xBEEF in cycle 2.
  - All outputs 0 before the request.
- **Simultaneous requests:** `if_req`, `ld_req` and `st_req` all asserted in one cycle, with `st_addr`=0x0020, `st_wdata`=0x1234 and `ld_addr`=0x0030.
  - Store first: `mem_we`=1, `mem_wdata`=0x1234.
  - Then the load, then the fetch.
  - `stall` drops in the cycle `ld_rvalid`=1.
- **Starvation:** `STARVE_LIMIT`=2; `ld_req` held high continuously with `if_req` high.
  - Order of grants is ld, ld, if, ld, ld, if.
- **Latency parameter:** `MEM_LATENCY`=3, load from 0x0040 with memory data 0x00AA.
  - `mem_en` in cycle 1, `ld_rvalid`=1 with 0x00AA exactly in cycle 4, `mem_en` low in cycles 2–4.
- **Reset mid-operation:** assert `rst_n`=0 during WAIT of a fetch.
  - All outputs 0 immediately.
  - No `if_rvalid` after release.
  - A new `if_req` is granted in the first cycle after release.
- **Late requests:** `ld_req` asserted while a fetch is in WAIT.
  - No `ld_gnt` until IDLE; `stall`=1 throughout the wait.
